// File: rtl/stm32_uart_rx.sv
// ---------------------------------------------------------------------------
// stm32_uart_rx
//   Receive side of the core <-> STM32 bootloader UART link (8E1 or 8N1, LSB
//   first). The serial input is synchronised and majority filtered. Framing
//   and parity are checked, and good bytes are queued in a small
//   first-word-fall-through FIFO. An armed response detector classifies the
//   next good byte as ACK (0x79), NACK (0x1F) or other. If no good byte
//   arrives in time, it signals a timeout instead.
//
// Ports
//   clk_sys      in   system clock
//   reset        in   asynchronous, active-high reset
//   uart_rxd     in   serial line from STM32 TX (idle high, asynchronous)
//   rx_data      out  FIFO head byte (0 while rx_valid=0)
//   rx_valid     out  FIFO not empty
//   rx_ready     in   consumer pop
//   resp_arm     in   start/restart a response wait (1-cycle pulse)
//   resp_busy    out  response wait armed
//   ack_pulse    out  first good byte after arm was 0x79
//   nack_pulse   out  first good byte after arm was 0x1F
//   resp_bad     out  first good byte after arm was some other value
//   resp_timeout out  no good byte within TIMEOUT_CYCLES
//   parity_err   out  sticky parity failure
//   frame_err    out  sticky framing failure (stop bit low)
//   overrun      out  sticky, good byte dropped on a full FIFO
//   err_clr      in   clears the sticky flags (a same-cycle set wins)
//   dbg_state    out  receiver FSM state
//
// Handshake: rx_valid/rx_ready follow strict valid/ready semantics. A byte
// leaves the FIFO on every cycle where both are high. rx_data is stable while
// rx_valid=1 and rx_ready=0. rx_valid never depends on rx_ready.
// ---------------------------------------------------------------------------
module stm32_uart_rx #(
    parameter int CLKS_PER_BIT   = 434,
    parameter int PARITY_EN      = 1,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       uart_rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic       resp_arm,
    output logic       resp_busy,
    output logic       ack_pulse,
    output logic       nack_pulse,
    output logic       resp_bad,
    output logic       resp_timeout,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    input  logic       err_clr,
    output logic [2:0] dbg_state
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int KW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [TW-1:0] HALF_M1  = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(CLKS_PER_BIT - 1);
    localparam logic [KW-1:0] TO_M1    = KW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
    localparam logic [2:0] ST_PARITY    = 3'd3;
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;

    // ---------------- state ----------------
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [2:0]    hist_q, hist_d;
    logic          s_prev_q, s_prev_d;
    logic [2:0]    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_ok_q, par_ok_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic          parity_err_q, parity_err_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          busy_q, busy_d;
    logic [KW-1:0] tcnt_q, tcnt_d;
    logic          ack_q, ack_d;
    logic          nack_q, nack_d;
    logic          bad_q, bad_d;
    logic          tout_q, tout_d;

    // ---------------- combinational helpers ----------------
    logic s;
    logic bit_done;
    logic byte_good;
    logic set_perr;
    logic set_ferr;
    logic fifo_full;
    logic push;
    logic pop;

    // The filtered line level is the majority of the last three synchronised samples.
    assign s = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
    assign bit_done = (timer_q == FULL_M1);

    always_comb begin
        sync1_d  = uart_rxd;
        sync2_d  = sync1_q;
        hist_d   = {hist_q[1:0], sync2_q};
        s_prev_d = s;
    end

    // Receiver FSM
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        par_ok_d  = par_ok_q;
        byte_good = 1'b0;
        set_perr  = 1'b0;
        set_ferr  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s_prev_q && !s) begin
                    state_d = ST_START;
                    timer_d = '0;
                end
            end
            ST_START: begin
                if (timer_q == HALF_M1) begin
                    // Re-check at mid start bit. A short glitch returns to IDLE silently.
                    timer_d   = '0;
                    bit_cnt_d = 3'd0;
                    state_d   = s ? ST_IDLE : ST_DATA;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    timer_d   = '0;
                    shift_d   = {s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        par_ok_d = 1'b1;
                        state_d  = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    timer_d  = '0;
                    par_ok_d = ~((^shift_q) ^ s);
                    state_d  = ST_STOP;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    timer_d = '0;
                    // Framing is checked first, so one frame never raises both errors.
                    if (!s) begin
                        set_ferr = 1'b1;
                        state_d  = ST_WAIT_IDLE;
                    end else if (!par_ok_q) begin
                        set_perr = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        byte_good = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_WAIT_IDLE: begin
                // Stay here through a break until the line returns high.
                if (s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO and sticky error flags
    always_comb begin
        fifo_full = (count_q == DEPTH_C);
        pop       = rx_valid && rx_ready;
        // When the FIFO is full, a push in the same cycle as a pop still fits.
        push      = byte_good && (!fifo_full || pop);
        wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);

        parity_err_d = set_perr | (parity_err_q & ~err_clr);
        frame_err_d  = set_ferr | (frame_err_q & ~err_clr);
        overrun_d    = (byte_good & fifo_full & ~pop) | (overrun_q & ~err_clr);
    end

    // Response detector
    always_comb begin
        busy_d = busy_q;
        tcnt_d = tcnt_q;
        ack_d  = 1'b0;
        nack_d = 1'b0;
        bad_d  = 1'b0;
        tout_d = 1'b0;
        if (resp_arm) begin
            // Arming takes priority over a same-cycle byte or timeout.
            busy_d = 1'b1;
            tcnt_d = '0;
        end else if (busy_q) begin
            if (byte_good) begin
                // A good byte is classified even if the full FIFO drops it.
                busy_d = 1'b0;
                ack_d  = (shift_q == 8'h79);
                nack_d = (shift_q == 8'h1F);
                bad_d  = (shift_q != 8'h79) && (shift_q != 8'h1F);
            end else if (tcnt_q == TO_M1) begin
                busy_d = 1'b0;
                tout_d = 1'b1;
            end else begin
                tcnt_d = tcnt_q + KW'(1);
            end
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            hist_q       <= 3'b111;
            s_prev_q     <= 1'b1;
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            par_ok_q     <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
            tcnt_q       <= '0;
            ack_q        <= 1'b0;
            nack_q       <= 1'b0;
            bad_q        <= 1'b0;
            tout_q       <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            hist_q       <= hist_d;
            s_prev_q     <= s_prev_d;
            state_q      <= state_d;
            timer_q      <= timer_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            par_ok_q     <= par_ok_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
            busy_q       <= busy_d;
            tcnt_q       <= tcnt_d;
            ack_q        <= ack_d;
            nack_q       <= nack_d;
            bad_q        <= bad_d;
            tout_q       <= tout_d;
        end
    end

    // FIFO storage has no reset; the pointers and count define what is valid.
    always_ff @(posedge clk_sys) begin
        if (push) mem_q[wr_ptr_q] <= shift_q;
    end

    // ---------------- outputs ----------------
    assign rx_valid     = (count_q != '0);
    assign rx_data      = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign resp_busy    = busy_q;
    assign ack_pulse    = ack_q;
    assign nack_pulse   = nack_q;
    assign resp_bad     = bad_q;
    assign resp_timeout = tout_q;
    assign parity_err   = parity_err_q;
    assign frame_err    = frame_err_q;
    assign overrun      = overrun_q;
    assign dbg_state    = state_q;

endmodule
